// File: rtl/idu_is_pipe2_iq_if.sv
// Dispatch-to-IQ and IQ-to-RF channels for execution pipe 2.
// The master modport is the environment side (dispatcher plus RF stage).
// The slave modport is the issue queue.
interface idu_is_pipe2_iq_if;
  // dispatch channel
  logic        dis_pipe2_vld;
  logic        dis_pipe2_rdy;
  logic [4:0]  dis_pipe2_iid;
  logic [6:0]  dis_pipe2_opcode;
  logic [6:0]  dis_pipe2_funct7;
  logic [2:0]  dis_pipe2_funct3;
  logic [63:0] dis_pipe2_pc;
  logic        dis_pipe2_psrc1_vld;
  logic [5:0]  dis_pipe2_psrc1;
  logic        dis_pipe2_psrc1_rdy;
  logic        dis_pipe2_psrc2_vld;
  logic [5:0]  dis_pipe2_psrc2;
  logic        dis_pipe2_psrc2_rdy;
  logic        dis_pipe2_pdst_vld;
  logic [5:0]  dis_pipe2_pdst;
  logic        dis_pipe2_imm_vld;
  logic [63:0] dis_pipe2_imm;

  // issue channel towards the RF stage
  logic        idu_idu_rf_pipe2_vld;
  logic [4:0]  idu_idu_rf_pipe2_iid;
  logic [6:0]  idu_idu_rf_pipe2_opcode;
  logic [6:0]  idu_idu_rf_pipe2_funct7;
  logic [2:0]  idu_idu_rf_pipe2_funct3;
  logic [63:0] idu_idu_rf_pipe2_pc;
  logic        idu_idu_rf_pipe2_psrc1_vld;
  logic [5:0]  idu_idu_rf_pipe2_psrc1;
  logic        idu_idu_rf_pipe2_psrc2_vld;
  logic [5:0]  idu_idu_rf_pipe2_psrc2;
  logic        idu_idu_rf_pipe2_pdst_vld;
  logic [5:0]  idu_idu_rf_pipe2_pdst;
  logic        idu_idu_rf_pipe2_imm_vld;
  logic [63:0] idu_idu_rf_pipe2_imm;

  modport master (
    output dis_pipe2_vld, dis_pipe2_iid, dis_pipe2_opcode, dis_pipe2_funct7,
           dis_pipe2_funct3, dis_pipe2_pc, dis_pipe2_psrc1_vld, dis_pipe2_psrc1,
           dis_pipe2_psrc1_rdy, dis_pipe2_psrc2_vld, dis_pipe2_psrc2,
           dis_pipe2_psrc2_rdy, dis_pipe2_pdst_vld, dis_pipe2_pdst,
           dis_pipe2_imm_vld, dis_pipe2_imm,
    input  dis_pipe2_rdy,
    input  idu_idu_rf_pipe2_vld, idu_idu_rf_pipe2_iid, idu_idu_rf_pipe2_opcode,
           idu_idu_rf_pipe2_funct7, idu_idu_rf_pipe2_funct3, idu_idu_rf_pipe2_pc,
           idu_idu_rf_pipe2_psrc1_vld, idu_idu_rf_pipe2_psrc1,
           idu_idu_rf_pipe2_psrc2_vld, idu_idu_rf_pipe2_psrc2,
           idu_idu_rf_pipe2_pdst_vld, idu_idu_rf_pipe2_pdst,
           idu_idu_rf_pipe2_imm_vld, idu_idu_rf_pipe2_imm
  );

  modport slave (
    input  dis_pipe2_vld, dis_pipe2_iid, dis_pipe2_opcode, dis_pipe2_funct7,
           dis_pipe2_funct3, dis_pipe2_pc, dis_pipe2_psrc1_vld, dis_pipe2_psrc1,
           dis_pipe2_psrc1_rdy, dis_pipe2_psrc2_vld, dis_pipe2_psrc2,
           dis_pipe2_psrc2_rdy, dis_pipe2_pdst_vld, dis_pipe2_pdst,
           dis_pipe2_imm_vld, dis_pipe2_imm,
    output dis_pipe2_rdy,
    output idu_idu_rf_pipe2_vld, idu_idu_rf_pipe2_iid, idu_idu_rf_pipe2_opcode,
           idu_idu_rf_pipe2_funct7, idu_idu_rf_pipe2_funct3, idu_idu_rf_pipe2_pc,
           idu_idu_rf_pipe2_psrc1_vld, idu_idu_rf_pipe2_psrc1,
           idu_idu_rf_pipe2_psrc2_vld, idu_idu_rf_pipe2_psrc2,
           idu_idu_rf_pipe2_pdst_vld, idu_idu_rf_pipe2_pdst,
           idu_idu_rf_pipe2_imm_vld, idu_idu_rf_pipe2_imm
  );
endinterface

// File: rtl/idu_is_pipe2_iq.sv
// Pipe-2 issue queue: collapsing age-ordered buffer with CDB wakeup and
// oldest-ready select. Entry 0 is always the oldest; valid entries are 0..cnt-1.
module idu_is_pipe2_iq #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             rtu_global_flush,
  idu_is_pipe2_iq_if.slave bus,
  input  logic             exu_idu_is_alu_wb_vld,
  input  logic [5:0]       exu_idu_is_alu_wb_preg,
  input  logic             exu_idu_is_mxu_wb_vld,
  input  logic [5:0]       exu_idu_is_mxu_wb_preg,
  input  logic             exu_idu_is_div_wb_vld,
  input  logic [5:0]       exu_idu_is_div_wb_preg,
  input  logic             exu_idu_is_lsu_wb_vld,
  input  logic [5:0]       exu_idu_is_lsu_wb_preg,
  input  logic             exu_idu_is_pipe2_stall,
  output logic [CNT_W-1:0] iq_pipe2_cnt
);

  typedef struct packed {
    logic [4:0]  iid;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] pc;
    logic        psrc1_vld;
    logic [5:0]  psrc1;
    logic        psrc2_vld;
    logic [5:0]  psrc2;
    logic        pdst_vld;
    logic [5:0]  pdst;
    logic        imm_vld;
    logic [63:0] imm;
  } ins_t;

  typedef struct packed {
    ins_t ins;
    logic rdy1;
    logic rdy2;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             shf   [DEPTH];
  logic             shf_vld [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0]       wb_vld;
  logic [3:0][5:0]  wb_preg;
  logic             sel_vld;
  logic [CNT_W-1:0] sel_idx;
  ins_t             iss;
  ent_t             dis_ent;
  logic             dis_rdy;
  logic             accept;
  logic [CNT_W-1:0] wr_idx;

  // True when any wakeup port broadcasts the given physical register
  function automatic logic wake_hit(input logic [5:0] preg, input logic [3:0] vld,
                                    input logic [3:0][5:0] pregs);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (vld[k] && (pregs[k] == preg)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign wb_vld  = {exu_idu_is_lsu_wb_vld, exu_idu_is_div_wb_vld,
                    exu_idu_is_mxu_wb_vld, exu_idu_is_alu_wb_vld};
  assign wb_preg = {exu_idu_is_lsu_wb_preg, exu_idu_is_div_wb_preg,
                    exu_idu_is_mxu_wb_preg, exu_idu_is_alu_wb_preg};

  // Full check uses registered occupancy only; an issue never frees a slot same-cycle
  assign dis_rdy = (cnt_q < CNT_W'(DEPTH));
  assign accept  = bus.dis_pipe2_vld && dis_rdy && !rtu_global_flush;
  assign wr_idx  = cnt_q - CNT_W'(sel_vld);

  // Incoming entry with ready bits including same-cycle wakeup bypass
  always_comb begin
    dis_ent = '0;
    dis_ent.ins.iid       = bus.dis_pipe2_iid;
    dis_ent.ins.opcode    = bus.dis_pipe2_opcode;
    dis_ent.ins.funct7    = bus.dis_pipe2_funct7;
    dis_ent.ins.funct3    = bus.dis_pipe2_funct3;
    dis_ent.ins.pc        = bus.dis_pipe2_pc;
    dis_ent.ins.psrc1_vld = bus.dis_pipe2_psrc1_vld;
    dis_ent.ins.psrc1     = bus.dis_pipe2_psrc1;
    dis_ent.ins.psrc2_vld = bus.dis_pipe2_psrc2_vld;
    dis_ent.ins.psrc2     = bus.dis_pipe2_psrc2;
    dis_ent.ins.pdst_vld  = bus.dis_pipe2_pdst_vld;
    dis_ent.ins.pdst      = bus.dis_pipe2_pdst;
    dis_ent.ins.imm_vld   = bus.dis_pipe2_imm_vld;
    dis_ent.ins.imm       = bus.dis_pipe2_imm;
    dis_ent.rdy1 = !bus.dis_pipe2_psrc1_vld || bus.dis_pipe2_psrc1_rdy ||
                   wake_hit(bus.dis_pipe2_psrc1, wb_vld, wb_preg);
    dis_ent.rdy2 = !bus.dis_pipe2_psrc2_vld || bus.dis_pipe2_psrc2_rdy ||
                   wake_hit(bus.dis_pipe2_psrc2, wb_vld, wb_preg);
  end

  // Oldest-ready select from registered ready bits
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    iss     = '0;
    if (!exu_idu_is_pipe2_stall && !rtu_global_flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!sel_vld && (CNT_W'(i) < cnt_q) && ent_q[i].rdy1 && ent_q[i].rdy2) begin
          sel_vld = 1'b1;
          sel_idx = CNT_W'(i);
          iss     = ent_q[i].ins;
        end
      end
    end
  end

  // Collapse: entries at and above the issued slot take their upper neighbour
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      shf[i]     = ent_q[i];
      shf_vld[i] = (CNT_W'(i) < cnt_q);
      if (sel_vld && (CNT_W'(i) >= sel_idx)) begin
        if (i < int'(DEPTH) - 1) begin
          shf[i]     = ent_q[(i + 1) % int'(DEPTH)];
          shf_vld[i] = (CNT_W'(i + 1) < cnt_q);
        end else begin
          shf[i]     = '0;
          shf_vld[i] = 1'b0;
        end
      end
    end
  end

  // Next entry state: wakeup on survivors, dispatch write, flush clear
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = '0;
      if (shf_vld[i]) begin
        ent_d[i] = shf[i];
        if (wake_hit(shf[i].ins.psrc1, wb_vld, wb_preg)) ent_d[i].rdy1 = 1'b1;
        if (wake_hit(shf[i].ins.psrc2, wb_vld, wb_preg)) ent_d[i].rdy2 = 1'b1;
      end
      if (accept && (CNT_W'(i) == wr_idx)) ent_d[i] = dis_ent;
      if (rtu_global_flush) ent_d[i] = '0;
    end
    if (rtu_global_flush) cnt_d = '0;
    else                  cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(sel_vld);
  end

  // Queue and occupancy registers
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
    end
  end

  assign iq_pipe2_cnt                   = cnt_q;
  assign bus.dis_pipe2_rdy              = dis_rdy;
  assign bus.idu_idu_rf_pipe2_vld       = sel_vld;
  assign bus.idu_idu_rf_pipe2_iid       = iss.iid;
  assign bus.idu_idu_rf_pipe2_opcode    = iss.opcode;
  assign bus.idu_idu_rf_pipe2_funct7    = iss.funct7;
  assign bus.idu_idu_rf_pipe2_funct3    = iss.funct3;
  assign bus.idu_idu_rf_pipe2_pc        = iss.pc;
  assign bus.idu_idu_rf_pipe2_psrc1_vld = iss.psrc1_vld;
  assign bus.idu_idu_rf_pipe2_psrc1     = iss.psrc1;
  assign bus.idu_idu_rf_pipe2_psrc2_vld = iss.psrc2_vld;
  assign bus.idu_idu_rf_pipe2_psrc2     = iss.psrc2;
  assign bus.idu_idu_rf_pipe2_pdst_vld  = iss.pdst_vld;
  assign bus.idu_idu_rf_pipe2_pdst      = iss.pdst;
  assign bus.idu_idu_rf_pipe2_imm_vld   = iss.imm_vld;
  assign bus.idu_idu_rf_pipe2_imm       = iss.imm;

endmodule
